r_ptr_empty_ctrl: RTL and testbench

- Read-domain pointer and status controller for the parametrised asynchronous FIFO. Next generation of the read-side block.
- Holds the binary read counter and its registered Gray pointer, which goes to the write domain.
- Synchronises the write Gray pointer through a parametrised number of flop stages.
- Produces registered empty, almost-empty and fill-level outputs, plus optional underflow detection.

---
 rtl/r_ptr_empty_ctrl.sv | 96 +++++++++
 tb/tb_r_ptr_empty_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/r_ptr_empty_ctrl.sv
// rtl/r_ptr_empty_ctrl.sv - FIFO read-domain pointer, write-pointer sync and empty/level status
// Optional sticky underflow detection: define R_UNDERFLOW_DET_EN.
module r_ptr_empty_ctrl #(
    parameter int ADDRESS_SIZE = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                    r_clk,
    input  logic                    rrst_n,
    input  logic                    r_en,
    input  logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic                    r_empty,
    output logic                    r_aempty,
    output logic [ADDRESS_SIZE:0]   r_count,
    output logic                    r_underflow
);

    localparam int P = ADDRESS_SIZE + 1;
    localparam logic [P-1:0] AEMPTY_LVL = P'(AEMPTY_LEVEL);

    logic [P-1:0] r_bin;
    logic [P-1:0] r_bnext;
    logic [P-1:0] r_gnext;
    logic [P-1:0] rq_wptr;
    logic [P-1:0] rq_wbin;
    logic [P-1:0] lvl_next;
    logic [P-1:0] sync_q [SYNC_STAGES];
    logic         rd_ok;

    assign rd_ok   = r_en & ~r_empty;
    assign r_bnext = r_bin + {{ADDRESS_SIZE{1'b0}}, rd_ok};
    assign r_gnext = r_bnext ^ (r_bnext >> 1);
    assign r_addr  = r_bin[ADDRESS_SIZE-1:0];
    assign rq_wptr = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        rq_wbin = '0;
        for (int i = 0; i < P; i++) begin
            rq_wbin[i] = ^(rq_wptr >> i);
        end
    end

    assign lvl_next = rq_wbin - r_bnext;

    always_ff @(posedge r_clk) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= w_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Flags compare against the next pointer so the last read raises empty
    // on the same edge that the address advances.
    always_ff @(posedge r_clk) begin
        if (!rrst_n) begin
            r_bin    <= '0;
            r_ptr    <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_count  <= '0;
        end else begin
            r_bin    <= r_bnext;
            r_ptr    <= r_gnext;
            r_empty  <= (r_gnext == rq_wptr);
            r_aempty <= (lvl_next <= AEMPTY_LVL);
            r_count  <= lvl_next;
        end
    end

`ifdef R_UNDERFLOW_DET_EN
    always_ff @(posedge r_clk) begin
        if (!rrst_n) begin
            r_underflow <= 1'b0;
        end else if (r_en && r_empty) begin
            r_underflow <= 1'b1;
`ifndef SYNTHESIS
            if (!r_underflow) begin
                $error("r_ptr_empty_ctrl: read requested while empty");
            end
`endif
        end
    end
`else
    assign r_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_r_ptr_empty_ctrl.sv
// tb/tb_r_ptr_empty_ctrl.sv - directed self-checking bench for r_ptr_empty_ctrl
module tb_r_ptr_empty_ctrl;

    logic       r_clk;
    logic       rrst_n;
    logic       r_en;
    logic [4:0] w_ptr;
    logic [4:0] r_ptr;
    logic [3:0] r_addr;
    logic       r_empty;
    logic       r_aempty;
    logic [4:0] r_count;
    logic       r_underflow;

    int checks   = 0;
    int failures = 0;

    r_ptr_empty_ctrl #(
        .ADDRESS_SIZE(4),
        .SYNC_STAGES (2),
        .AEMPTY_LEVEL(2)
    ) dut (
        .r_clk      (r_clk),
        .rrst_n     (rrst_n),
        .r_en       (r_en),
        .w_ptr      (w_ptr),
        .r_ptr      (r_ptr),
        .r_addr     (r_addr),
        .r_empty    (r_empty),
        .r_aempty   (r_aempty),
        .r_count    (r_count),
        .r_underflow(r_underflow)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, 32'(r_addr), 32'd0);
        check({tag, "_ptr"}, 32'(r_ptr), 32'd0);
        check({tag, "_empty"}, 32'(r_empty), 32'd1);
        check({tag, "_aempty"}, 32'(r_aempty), 32'd1);
        check({tag, "_count"}, 32'(r_count), 32'd0);
        check({tag, "_uflow"}, 32'(r_underflow), 32'd0);
    endtask

    // Reset with a given write pointer, release, then let it cross the synchroniser.
    task automatic restart(input logic [4:0] wp);
        rrst_n = 1'b0;
        r_en   = 1'b0;
        w_ptr  = wp;
        tick();
        rrst_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    logic [4:0] prev_ptr;
    logic       exp_uflow;

    initial begin
        rrst_n = 1'b0;
        r_en   = 1'b0;
        w_ptr  = gray(5);
`ifdef R_UNDERFLOW_DET_EN
        exp_uflow = 1'b1;
`else
        exp_uflow = 1'b0;
`endif

        // 1: reset visibility
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_state("rst_hold");
        end
        rrst_n = 1'b1;
        tick();
        check("rel1_empty", 32'(r_empty), 32'd1);
        tick();
        check("rel2_empty", 32'(r_empty), 32'd1);
        tick();
        check("rel3_empty", 32'(r_empty), 32'd0);
        check("rel3_count", 32'(r_count), 32'd5);
        check("rel3_aempty", 32'(r_aempty), 32'd0);

        // 2: drain three entries
        restart(gray(3));
        check("drain_count0", 32'(r_count), 32'd3);
        check("drain_aempty0", 32'(r_aempty), 32'd0);
        check("drain_empty0", 32'(r_empty), 32'd0);
        r_en = 1'b1;
        tick();
        check("drain_addr1", 32'(r_addr), 32'd1);
        check("drain_count1", 32'(r_count), 32'd2);
        check("drain_aempty1", 32'(r_aempty), 32'd1);
        check("drain_empty1", 32'(r_empty), 32'd0);
        tick();
        check("drain_addr2", 32'(r_addr), 32'd2);
        check("drain_count2", 32'(r_count), 32'd1);
        check("drain_empty2", 32'(r_empty), 32'd0);
        tick();
        check("drain_addr3", 32'(r_addr), 32'd3);
        check("drain_count3", 32'(r_count), 32'd0);
        check("drain_empty3", 32'(r_empty), 32'd1);

        // 3: reads while empty are ignored
        for (int i = 0; i < 2; i++) begin
            tick();
            check("uflow_addr", 32'(r_addr), 32'd3);
            check("uflow_ptr", 32'(r_ptr), 32'(gray(3)));
            check("uflow_empty", 32'(r_empty), 32'd1);
            check("uflow_flag", 32'(r_underflow), 32'(exp_uflow));
        end
        r_en = 1'b0;

        // 4: one write then one read, 33 times, across the pointer wrap
        restart(gray(0));
        for (int k = 0; k < 33; k++) begin
            w_ptr = gray(k + 1);
            tick();
            tick();
            tick();
            check("wrap_vis_empty", 32'(r_empty), 32'd0);
            check("wrap_vis_count", 32'(r_count), 32'd1);
            prev_ptr = r_ptr;
            r_en = 1'b1;
            tick();
            r_en = 1'b0;
            check("wrap_addr", 32'(r_addr), 32'((k + 1) % 16));
            check("wrap_ptr", 32'(r_ptr), 32'(gray((k + 1) % 32)));
            check("wrap_onebit", 32'($countones(prev_ptr ^ r_ptr)), 32'd1);
            check("wrap_empty", 32'(r_empty), 32'd1);
            check("wrap_count", 32'(r_count), 32'd0);
        end

        // 5: reset in the middle of a read
        restart(gray(9));
        r_en = 1'b1;
        tick();
        tick();
        check("mid_count7", 32'(r_count), 32'd7);
        check("mid_addr2", 32'(r_addr), 32'd2);
        rrst_n = 1'b0;
        tick();
        check_reset_state("mid_rst");
        rrst_n = 1'b1;
        r_en   = 1'b0;

        // 6: full level, drain to one, last read meets a remote write
        restart(gray(16));
        check("full_count", 32'(r_count), 32'h10);
        check("full_empty", 32'(r_empty), 32'd0);
        check("full_aempty", 32'(r_aempty), 32'd0);
        r_en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("full_drain_count", 32'(r_count), 32'd1);
        check("full_drain_addr", 32'(r_addr), 32'd15);
        check("full_drain_aempty", 32'(r_aempty), 32'd1);
        w_ptr = gray(17);
        tick();
        r_en = 1'b0;
        check("sim_empty_e0", 32'(r_empty), 32'd1);
        check("sim_addr_e0", 32'(r_addr), 32'd0);
        tick();
        check("sim_empty_e1", 32'(r_empty), 32'd1);
        tick();
        check("sim_empty_e2", 32'(r_empty), 32'd0);
        check("sim_count_e2", 32'(r_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
